// File: rtl/mem_wb_stage.sv
// MEM stage and MEM/WB pipeline register: drives the data-memory req/ack port, aligns load data.
// Optional macro MEM_ALIGN_CHECK_EN traps misaligned half/word accesses instead of issuing them.
module mem_wb_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_mem_valid,
   input  logic [4:0]  ex_mem_wreg,
   input  logic        ex_mem_RegWrite,
   input  logic        ex_mem_MemRead,
   input  logic        ex_mem_MemWrite,
   input  logic [31:0] ex_mem_alu_result,
   input  logic [31:0] ex_mem_store_data,
   input  logic [1:0]  ex_mem_size,
   input  logic        ex_mem_sign,
   output logic        mem_stall,
   output logic        dm_req,
   output logic        dm_we,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_wdata,
   output logic [3:0]  dm_wstrb,
   input  logic        dm_ack,
   input  logic [31:0] dm_rdata,
   output logic [4:0]  mem_wb_wreg,
   output logic        mem_wb_RegWrite,
   output logic [31:0] mem_wb_wdata,
   output logic        mem_excp
);

   // Handshake: dm_req rises on the edge leaving IDLE and every dm_* output stays frozen
   // until the first cycle that samples dm_ack high; that edge completes the access.
   typedef enum logic {IDLE, REQ} state_t;

   state_t      state_q, state_d;
   logic        dm_req_q, dm_req_d;
   logic        dm_we_q, dm_we_d;
   logic [31:0] dm_addr_q, dm_addr_d;
   logic [31:0] dm_wdata_q, dm_wdata_d;
   logic [3:0]  dm_wstrb_q, dm_wstrb_d;
   logic [1:0]  size_q, size_d;
   logic        sign_q, sign_d;
   logic [1:0]  off_q, off_d;
   logic [4:0]  wreg_q, wreg_d;
   logic [4:0]  mem_wb_wreg_q, mem_wb_wreg_d;
   logic        mem_wb_regwrite_q, mem_wb_regwrite_d;
   logic [31:0] mem_wb_wdata_q, mem_wb_wdata_d;

   logic        memop;
   logic [1:0]  ex_off;
   logic [3:0]  strb_fmt;
   logic [31:0] wdata_fmt;
   logic [7:0]  byte_lane;
   logic [15:0] half_lane;
   logic [31:0] load_data;

   assign memop  = ex_mem_valid & (ex_mem_MemRead | ex_mem_MemWrite);
   assign ex_off = ex_mem_alu_result[1:0];

   always_comb begin
      strb_fmt  = 4'b1111;
      wdata_fmt = ex_mem_store_data;
      case (ex_mem_size)
         2'd0: begin
            strb_fmt  = 4'b0001 << ex_off;
            wdata_fmt = {4{ex_mem_store_data[7:0]}};
         end
         2'd1: begin
            strb_fmt  = ex_off[1] ? 4'b1100 : 4'b0011;
            wdata_fmt = {2{ex_mem_store_data[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      byte_lane = dm_rdata[7:0];
      case (off_q)
         2'd1:    byte_lane = dm_rdata[15:8];
         2'd2:    byte_lane = dm_rdata[23:16];
         2'd3:    byte_lane = dm_rdata[31:24];
         default: ;
      endcase
      half_lane = off_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
      case (size_q)
         2'd0:    load_data = {{24{sign_q & byte_lane[7]}}, byte_lane};
         2'd1:    load_data = {{16{sign_q & half_lane[15]}}, half_lane};
         default: load_data = dm_rdata;
      endcase
   end

`ifdef MEM_ALIGN_CHECK_EN
   logic misalign;
   logic mem_excp_q, mem_excp_d;
   assign misalign = (ex_mem_size == 2'd1) ? ex_off[0] :
                     (ex_mem_size[1] ? (ex_off != 2'd0) : 1'b0);
   assign mem_excp = mem_excp_q;
`else
   assign mem_excp = 1'b0;
`endif

   always_comb begin
      state_d           = state_q;
      dm_req_d          = dm_req_q;
      dm_we_d           = dm_we_q;
      dm_addr_d         = dm_addr_q;
      dm_wdata_d        = dm_wdata_q;
      dm_wstrb_d        = dm_wstrb_q;
      size_d            = size_q;
      sign_d            = sign_q;
      off_d             = off_q;
      wreg_d            = wreg_q;
      mem_wb_wreg_d     = mem_wb_wreg_q;
      mem_wb_regwrite_d = 1'b0;
      mem_wb_wdata_d    = mem_wb_wdata_q;
      mem_stall         = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      mem_excp_d        = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (memop) begin
`ifdef MEM_ALIGN_CHECK_EN
               if (misalign) mem_excp_d = 1'b1;
               else
`endif
               begin
                  mem_stall  = 1'b1;
                  state_d    = REQ;
                  dm_req_d   = 1'b1;
                  dm_we_d    = ex_mem_MemWrite;
                  dm_addr_d  = {ex_mem_alu_result[31:2], 2'b00};
                  dm_wdata_d = wdata_fmt;
                  dm_wstrb_d = ex_mem_MemWrite ? strb_fmt : 4'b0000;
                  size_d     = ex_mem_size;
                  sign_d     = ex_mem_sign;
                  off_d      = ex_off;
                  wreg_d     = ex_mem_wreg;
               end
            end else if (ex_mem_valid) begin
               mem_wb_wreg_d     = ex_mem_wreg;
               mem_wb_regwrite_d = ex_mem_RegWrite & (ex_mem_wreg != 5'd0);
               mem_wb_wdata_d    = ex_mem_alu_result;
            end
         end
         REQ: begin
            mem_stall = ~dm_ack;
            if (dm_ack) begin
               state_d       = IDLE;
               dm_req_d      = 1'b0;
               mem_wb_wreg_d = wreg_q;
               if (!dm_we_q) begin
                  mem_wb_wdata_d    = load_data;
                  mem_wb_regwrite_d = (wreg_q != 5'd0);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q           <= IDLE;
         dm_req_q          <= 1'b0;
         dm_we_q           <= 1'b0;
         dm_addr_q         <= 32'd0;
         dm_wdata_q        <= 32'd0;
         dm_wstrb_q        <= 4'd0;
         size_q            <= 2'd0;
         sign_q            <= 1'b0;
         off_q             <= 2'd0;
         wreg_q            <= 5'd0;
         mem_wb_wreg_q     <= 5'd0;
         mem_wb_regwrite_q <= 1'b0;
         mem_wb_wdata_q    <= 32'd0;
`ifdef MEM_ALIGN_CHECK_EN
         mem_excp_q        <= 1'b0;
`endif
      end else begin
         state_q           <= state_d;
         dm_req_q          <= dm_req_d;
         dm_we_q           <= dm_we_d;
         dm_addr_q         <= dm_addr_d;
         dm_wdata_q        <= dm_wdata_d;
         dm_wstrb_q        <= dm_wstrb_d;
         size_q            <= size_d;
         sign_q            <= sign_d;
         off_q             <= off_d;
         wreg_q            <= wreg_d;
         mem_wb_wreg_q     <= mem_wb_wreg_d;
         mem_wb_regwrite_q <= mem_wb_regwrite_d;
         mem_wb_wdata_q    <= mem_wb_wdata_d;
`ifdef MEM_ALIGN_CHECK_EN
         mem_excp_q        <= mem_excp_d;
`endif
      end
   end

   assign dm_req          = dm_req_q;
   assign dm_we           = dm_we_q;
   assign dm_addr         = dm_addr_q;
   assign dm_wdata        = dm_wdata_q;
   assign dm_wstrb        = dm_wstrb_q;
   assign mem_wb_wreg     = mem_wb_wreg_q;
   assign mem_wb_RegWrite = mem_wb_regwrite_q;
   assign mem_wb_wdata    = mem_wb_wdata_q;

endmodule
